// File: rtl/fpu_csr_pkg.sv
// Shared encodings for the FPU CSR sequencer: Zicsr funct3 values, FPU CSR addresses and FSM states.
package fpu_csr_pkg;

   localparam logic [2:0] F3_RW  = 3'b001;
   localparam logic [2:0] F3_RS  = 3'b010;
   localparam logic [2:0] F3_RC  = 3'b011;
   localparam logic [2:0] F3_RWI = 3'b101;
   localparam logic [2:0] F3_RSI = 3'b110;
   localparam logic [2:0] F3_RCI = 3'b111;

   localparam logic [11:0] CSR_FFLAGS = 12'h001;
   localparam logic [11:0] CSR_FRM    = 12'h002;
   localparam logic [11:0] CSR_FCSR   = 12'h003;

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_e;

   // Low two funct3 bits select the modify op for both register and immediate forms.
   typedef enum logic [1:0] {OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;

   function automatic logic csr_addr_ok(input logic [11:0] a);
      return (a == CSR_FFLAGS) || (a == CSR_FRM) || (a == CSR_FCSR);
   endfunction

endpackage

// File: rtl/fpu_csr_seq_alu.sv
// Read-modify-write datapath: combines the old CSR value with the operand for RW/RS/RC.
module fpu_csr_seq_alu
   import fpu_csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  csr_op_e           op_i,
   input  logic [XLEN-1:0]   old_i,
   input  logic [XLEN-1:0]   opnd_i,
   output logic [XLEN-1:0]   res_o
);

   always_comb begin
      case (op_i)
         OP_RS:   res_o = old_i | opnd_i;
         OP_RC:   res_o = old_i & ~opnd_i;
         default: res_o = opnd_i;
      endcase
   end

endmodule

// File: rtl/fpu_csr_sequencer.sv
// Zicsr initiator for the FPU CSR port: IDLE -> [READ] -> [WRITE] -> RESP.
// Define FPU_CSR_SEQ_IMM_EN to accept the immediate forms (CSRRWI/CSRRSI/CSRRCI).
module fpu_csr_sequencer
   import fpu_csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        funct3,
   input  logic [11:0]       csr_addr,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [4:0]        zimm,
   input  logic              rs1_is_x0,
   input  logic              rd_is_x0,
   input  logic              fpu_busy,
   output logic              csr_read,
   output logic              csr_write,
   output logic [11:0]       csr_addr_o,
   output logic [XLEN-1:0]   csr_wdata,
   input  logic [XLEN-1:0]   csr_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_data,
   output logic              rsp_illegal
);

   state_e            state_q, state_d;
   csr_op_e           op_q, op_d;
   logic [11:0]       addr_q, addr_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [XLEN-1:0]   old_q, old_d;
   logic              wr_q, wr_d;
   logic              ill_q, ill_d;
   logic              f3_ok, do_rd;
   logic [XLEN-1:0]   alu_res;

   fpu_csr_seq_alu #(.XLEN(XLEN)) u_alu (
      .op_i   (op_q),
      .old_i  (old_q),
      .opnd_i (opnd_q),
      .res_o  (alu_res)
   );

`ifdef FPU_CSR_SEQ_IMM_EN
   assign f3_ok = (funct3 == F3_RW) || (funct3 == F3_RS) || (funct3 == F3_RC) ||
                  (funct3 == F3_RWI) || (funct3 == F3_RSI) || (funct3 == F3_RCI);
`else
   assign f3_ok = (funct3 == F3_RW) || (funct3 == F3_RS) || (funct3 == F3_RC);
`endif

   // RW-class ops with rd=x0 have no architectural read side effect, so skip it.
   assign do_rd = !((funct3[1:0] == 2'b01) && rd_is_x0);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      opnd_d      = opnd_q;
      old_d       = old_q;
      wr_d        = wr_q;
      ill_d       = ill_q;
      instr_ready = 1'b0;
      csr_read    = 1'b0;
      csr_write   = 1'b0;
      csr_addr_o  = '0;
      csr_wdata   = '0;
      rsp_valid   = 1'b0;
      rsp_data    = '0;
      rsp_illegal = 1'b0;
      case (state_q)
         ST_IDLE: begin
            instr_ready = !fpu_busy;
            if (instr_valid && !fpu_busy) begin
               op_d   = csr_op_e'(funct3[1:0]);
               addr_d = csr_addr;
               opnd_d = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1_data;
               wr_d   = (funct3[1:0] == 2'b01) || !rs1_is_x0;
               old_d  = '0;
               ill_d  = !f3_ok || !csr_addr_ok(csr_addr);
               if (ill_d)      state_d = ST_RESP;
               else if (do_rd) state_d = ST_READ;
               else            state_d = ST_WRITE;
            end
         end
         ST_READ: begin
            csr_read   = 1'b1;
            csr_addr_o = addr_q;
            old_d      = csr_rdata;
            state_d    = wr_q ? ST_WRITE : ST_RESP;
         end
         ST_WRITE: begin
            csr_write  = 1'b1;
            csr_addr_o = addr_q;
            csr_wdata  = alu_res;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid   = 1'b1;
            rsp_data    = old_q;
            rsp_illegal = ill_q;
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Keep the responder quiet during reset even if the FSM was mid-sequence.
      if (rst) begin
         instr_ready = 1'b0;
         csr_read    = 1'b0;
         csr_write   = 1'b0;
         csr_addr_o  = '0;
         csr_wdata   = '0;
         rsp_valid   = 1'b0;
         rsp_data    = '0;
         rsp_illegal = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NONE;
         addr_q  <= '0;
         opnd_q  <= '0;
         old_q   <= '0;
         wr_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         opnd_q  <= opnd_d;
         old_q   <= old_d;
         wr_q    <= wr_d;
         ill_q   <= ill_d;
      end
   end

endmodule

// File: tb/tb_fpu_csr_sequencer.sv
// Bench for fpu_csr_sequencer with a behavioural FPU CSR responder and transaction-level model.
module tb_fpu_csr_sequencer;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic            instr_valid = 1'b0, instr_ready;
   logic [2:0]      funct3 = '0;
   logic [11:0]     csr_addr = '0;
   logic [XLEN-1:0] rs1_data = '0;
   logic [4:0]      zimm = '0;
   logic            rs1_is_x0 = 1'b0, rd_is_x0 = 1'b0, fpu_busy = 1'b0;
   logic            csr_read, csr_write;
   logic [11:0]     csr_addr_o;
   logic [XLEN-1:0] csr_wdata, csr_rdata;
   logic            rsp_valid, rsp_ready = 1'b0;
   logic [XLEN-1:0] rsp_data;
   logic            rsp_illegal;

   fpu_csr_sequencer #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .funct3(funct3), .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm),
      .rs1_is_x0(rs1_is_x0), .rd_is_x0(rd_is_x0), .fpu_busy(fpu_busy),
      .csr_read(csr_read), .csr_write(csr_write), .csr_addr_o(csr_addr_o),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_illegal(rsp_illegal)
   );

   // Responder: fcsr = {frm[2:0], fflags[4:0]}, combinational read, write on clock edge.
   logic [7:0] fcsr_r;
   logic       pl_en = 1'b0;
   logic [7:0] pl_val = '0;

   always_comb begin
      case (csr_addr_o)
         12'h001: csr_rdata = {27'b0, fcsr_r[4:0]};
         12'h002: csr_rdata = {29'b0, fcsr_r[7:5]};
         12'h003: csr_rdata = {24'b0, fcsr_r};
         default: csr_rdata = '0;
      endcase
   end

   always @(posedge clk) begin
      if (pl_en) fcsr_r <= pl_val;
      else if (csr_write) begin
         case (csr_addr_o)
            12'h001: fcsr_r[4:0] <= csr_wdata[4:0];
            12'h002: fcsr_r[7:5] <= csr_wdata[2:0];
            12'h003: fcsr_r      <= csr_wdata[7:0];
            default: ;
         endcase
      end
   end

   int checks = 0;
   int failures = 0;
   logic [7:0] m_fcsr = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a, input logic [7:0] f);
      case (a)
         12'h001: return {27'b0, f[4:0]};
         12'h002: return {29'b0, f[7:5]};
         12'h003: return {24'b0, f};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [7:0] m_commit(input logic [11:0] a, input logic [7:0] f,
                                           input logic [31:0] wd);
      case (a)
         12'h001: return {f[7:5], wd[4:0]};
         12'h002: return {wd[2:0], f[4:0]};
         12'h003: return wd[7:0];
         default: return f;
      endcase
   endfunction

   task automatic preload(input logic [7:0] v);
      @(negedge clk);
      pl_en = 1'b1; pl_val = v;
      @(posedge clk);
      #1 pl_en = 1'b0;
      m_fcsr = v;
   endtask

   task automatic do_instr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] r1,
                           input logic [4:0] zi, input bit r1x0, input bit rdx0,
                           input int busy_n, input int hold_n, input bit busy_after);
      bit legal, is_rw, is_rs, e_rd, e_wr;
      logic [31:0] opnd, old, e_wd, got_wd, first_data;
      int e_lat, lat, nr, nw;
      bit imm_ok;
`ifdef FPU_CSR_SEQ_IMM_EN
      imm_ok = 1'b1;
`else
      imm_ok = 1'b0;
`endif
      is_rw = (f3 == 3'b001) || (f3 == 3'b101);
      is_rs = (f3 == 3'b010) || (f3 == 3'b110);
      legal = (a == 12'h001 || a == 12'h002 || a == 12'h003) &&
              ((f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011) ||
               (imm_ok && (f3 == 3'b101 || f3 == 3'b110 || f3 == 3'b111)));
      opnd  = (f3 >= 3'd5) ? {27'b0, zi} : r1;
      e_rd  = legal && !(is_rw && rdx0);
      e_wr  = legal && (is_rw || !r1x0);
      old   = e_rd ? m_read(a, m_fcsr) : 32'h0;
      if (is_rw)      e_wd = opnd;
      else if (is_rs) e_wd = old | opnd;
      else            e_wd = old & ~opnd;
      e_lat = legal ? (1 + int'(e_rd) + int'(e_wr)) : 1;

      @(negedge clk);
      funct3 = f3; csr_addr = a; rs1_data = r1; zimm = zi;
      rs1_is_x0 = r1x0; rd_is_x0 = rdx0; instr_valid = 1'b1;
      fpu_busy = (busy_n > 0);
      for (int i = 0; i < busy_n; i++) begin
         #1 chk("busy_blocks_ready", 32'(instr_ready), 32'd0);
         @(negedge clk);
      end
      fpu_busy = 1'b0;
      #1 chk("idle_ready", 32'(instr_ready), 32'd1);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      fpu_busy = busy_after;

      lat = 0; nr = 0; nw = 0; got_wd = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         nr += int'(csr_read);
         nw += int'(csr_write);
         if (csr_write) got_wd = csr_wdata;
         if (csr_read && csr_write) chk("strobe_overlap", 32'd1, 32'd0);
         if (csr_read || csr_write) chk("strobe_addr", 32'(csr_addr_o), 32'(a));
         else begin
            if (csr_addr_o !== 12'h0) chk("idle_addr_zero", 32'(csr_addr_o), 32'd0);
            if (csr_wdata !== '0) chk("idle_wdata_zero", csr_wdata, 32'd0);
         end
         if (!csr_write && csr_wdata !== '0) chk("wdata_no_write", csr_wdata, 32'd0);
         if (instr_ready) chk("ready_in_flight", 32'(instr_ready), 32'd0);
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
      chk("rsp_latency", 32'(lat), 32'(e_lat));
      chk("read_count", 32'(nr), 32'(int'(e_rd)));
      chk("write_count", 32'(nw), 32'(int'(e_wr)));
      if (e_wr) chk("wdata", got_wd, e_wd);
      chk("rsp_data", rsp_data, legal ? old : 32'h0);
      chk("rsp_illegal", 32'(rsp_illegal), 32'(!legal));
      first_data = rsp_data;
      for (int h = 0; h < hold_n; h++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_data", rsp_data, first_data);
         chk("hold_ready_low", 32'(instr_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      fpu_busy = 1'b0;
      if (e_wr) m_fcsr = m_commit(a, m_fcsr, e_wd);
      @(negedge clk);
      chk("fcsr_state", 32'(fcsr_r), 32'(m_fcsr));
      chk("post_hs_valid", 32'(rsp_valid), 32'd0);
      chk("post_hs_ready", 32'(instr_ready), 32'd1);
   endtask

   initial begin
      logic [11:0] addrs [6];
      addrs[0] = 12'h001; addrs[1] = 12'h002; addrs[2] = 12'h003;
      addrs[3] = 12'h003; addrs[4] = 12'h300; addrs[5] = 12'h000;

      // Reset behaviour.
      pl_en = 1'b1; pl_val = 8'h00;
      instr_valid = 1'b1; funct3 = 3'b001; csr_addr = 12'h003;
      repeat (2) @(negedge clk);
      pl_en = 1'b0;
      chk("rst_ready", 32'(instr_ready), 32'd0);
      chk("rst_read", 32'(csr_read), 32'd0);
      chk("rst_write", 32'(csr_write), 32'd0);
      chk("rst_addr", 32'(csr_addr_o), 32'd0);
      chk("rst_wdata", csr_wdata, 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data", rsp_data, 32'd0);
      chk("rst_illegal", 32'(rsp_illegal), 32'd0);
      instr_valid = 1'b0;
      rst = 1'b0;
      m_fcsr = 8'h00;

      // CSRRW fcsr: full RMW.
      preload(8'h20);
      do_instr(3'b001, 12'h003, 32'h0000_00E1, 5'd0, 1'b0, 1'b0, 0, 0, 1'b0);
      // CSRRS fflags with rs1=x0: read only.
      preload(8'h1F);
      do_instr(3'b010, 12'h001, 32'h0, 5'd0, 1'b1, 1'b0, 0, 0, 1'b0);
      // CSRRCI frm: full RMW with macro, illegal without.
      preload(8'hE0);
      do_instr(3'b111, 12'h002, 32'h0, 5'h03, 1'b0, 1'b0, 0, 0, 1'b0);
      // Illegal address / funct3.
      do_instr(3'b001, 12'h300, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 0, 0, 1'b0);
      do_instr(3'b100, 12'h003, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 0, 0, 1'b0);
      // CSRRW with rd=x0: write only.
      do_instr(3'b001, 12'h001, 32'hFFFF_FF15, 5'd0, 1'b0, 1'b1, 0, 0, 1'b0);
      // Busy gating and stalled response.
      do_instr(3'b011, 12'h003, 32'h0000_0081, 5'd0, 1'b0, 1'b0, 3, 5, 1'b1);

      // Reset during READ drops the instruction without writing.
      preload(8'h5A);
      @(negedge clk);
      funct3 = 3'b001; csr_addr = 12'h003; rs1_data = 32'hFF; rs1_is_x0 = 1'b0; rd_is_x0 = 1'b0;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      chk("midrst_in_read", 32'(csr_read), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_no_write", 32'(csr_write), 32'd0);
      chk("midrst_no_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 32'(instr_ready), 32'd1);
      chk("midrst_no_valid2", 32'(rsp_valid), 32'd0);
      chk("midrst_fcsr", 32'(fcsr_r), 32'(m_fcsr));

      // Randomized transactions.
      for (int n = 0; n < 40; n++) begin
         logic [2:0]  f3;
         logic [11:0] a;
         logic [31:0] r1;
         logic [4:0]  zi;
         bit r1x0, rdx0;
         f3   = 3'($urandom_range(0, 7));
         a    = addrs[$urandom_range(0, 5)];
         r1   = $urandom;
         zi   = 5'($urandom);
         r1x0 = ($urandom_range(0, 3) == 0);
         rdx0 = ($urandom_range(0, 3) == 0);
         if (r1x0) begin r1 = '0; zi = '0; end
         do_instr(f3, a, r1, zi, r1x0, rdx0, int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpu_csr_sequencer.md
# fpu_csr_sequencer

Initiator side of the FPU CSR access port. Accepts one decoded Zicsr instruction at a time, runs the read/modify/write sequence against the FPU CSR responder (fflags 0x001, frm 0x002, fcsr 0x003), and returns the old CSR value for writeback to rd. It sits between the core's instruction issue path and the FPU CSR block, which returns read data combinationally and commits writes on the next clock edge.

## Interface
Parameters:
- XLEN, 32, data width of rs1, CSR read/write data and response data

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept; high only in IDLE with fpu_busy low
- funct3  in  3  Zicsr op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csr_addr  in  12  target CSR address
- rs1_data  in  XLEN  register operand
- zimm  in  5  immediate operand (zero-extended)
- rs1_is_x0  in  1  rs1/zimm field is zero
- rd_is_x0  in  1  destination is x0
- fpu_busy  in  1  FPU operation in flight; blocks acceptance
- csr_read  out  1  read strobe to responder
- csr_write  out  1  write strobe to responder
- csr_addr_o  out  12  address to responder
- csr_wdata  out  XLEN  write data to responder
- csr_rdata  in  XLEN  combinational read data from responder
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  XLEN  old CSR value (0 if read skipped or illegal)
- rsp_illegal  out  1  instruction raised illegal-instruction

## Operation
- States: IDLE, READ, WRITE, RESP. Accept on instr_valid & instr_ready; latch funct3, address, operand (rs1_data or zimm per funct3[2]), rs1_is_x0, rd_is_x0.
- Illegal when funct3 ∈ {000, 100} or csr_addr ∉ {001, 002, 003}: IDLE→RESP, no strobes, rsp_illegal=1, rsp_data=0.
- Read skipped only for RW/RWI with rd_is_x0; otherwise IDLE→READ.
- Write skipped for RS/RC/RSI/RCI with rs1_is_x0; RW/RWI always write.
- READ: csr_read=1, csr_addr_o=latched address; capture csr_rdata into old register at end of cycle; →WRITE or →RESP.
- WRITE: csr_write=1; csr_wdata = operand (RW), old | operand (RS), old & ~operand (RC); old=0 if read skipped; →RESP.
- RESP: rsp_valid=1 held with stable rsp_data/rsp_illegal until rsp_ready; →IDLE on handshake.
- csr_read and csr_write never asserted in the same cycle; csr_addr_o/csr_wdata are 0 when no strobe.

## Timing
- Reset values: instr_ready=0 during reset, csr_read=0, csr_write=0, csr_addr_o=0, csr_wdata=0, rsp_valid=0, rsp_data=0, rsp_illegal=0; state IDLE.
- Accept at cycle 0: full RMW gives READ cycle 1, WRITE cycle 2, rsp_valid cycle 3. One stage skipped: rsp_valid cycle 2. Illegal: rsp_valid cycle 1.
- Throughput: no new accept until the cycle after the response handshake (instr_ready low in RESP).
- rsp_ready held low: stays in RESP indefinitely, outputs stable.
- fpu_busy only gates acceptance; it is ignored after accept.
- rst mid-sequence: return to IDLE next edge, drop in-flight instruction, no write issued after the reset edge.

## Configuration
- FPU_CSR_SEQ_IMM_EN defined: funct3 101/110/111 supported, operand = zero-extended zimm.
- Undefined: funct3 101/110/111 treated as illegal (IDLE→RESP, rsp_illegal=1, no strobes).

## Structure
- Package fpu_csr_pkg: funct3 encodings, CSR address constants (FFLAGS 12'h001, FRM 12'h002, FCSR 12'h003), state encoding.
- One sub-module fpu_csr_seq_alu: combinational RW/RS/RC modify of old value with operand.

## Test plan
- CSRRW fcsr, rs1_data=0x000000E1, prior fcsr=0x00000020 -> READ then WRITE csr_wdata=0xE1, rsp_data=0x20 at cycle 3.
- CSRRS fflags, rs1_is_x0=1, fflags=0x1F -> READ only, no csr_write, rsp_data=0x1F at cycle 2.
- CSRRCI frm, zimm=0x03, frm=0x7 -> csr_wdata=0x4, rsp_data=0x7 (macro on); same stimulus with macro off -> rsp_illegal=1, no strobes.
- csr_addr=0x300 or funct3=100 -> rsp_valid cycle 1, rsp_illegal=1, rsp_data=0, no strobes.
- fpu_busy=1 with instr_valid=1 -> instr_ready=0 until fpu_busy falls; rsp_ready low 5 cycles -> rsp_data stable.
- rst asserted in READ cycle -> no csr_write, rsp_valid stays 0, instr_ready high next cycle after rst release.
